// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator and the data memory responder.
// The initiator drives the request fields and rsp_ready; the responder drives the rest.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering byte/half/word loads and stores after a
// fixed number of wait cycles, with alignment and range checking.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output logic                 busy
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Error priority: reserved size, then misalignment, then out-of-range address.
    function automatic logic access_error(input logic [1:0] size, input logic [31:0] addr);
        logic err;
        case (size)
            2'b00:   err = 1'b0;
            2'b01:   err = addr[0];
            2'b10:   err = (addr[1:0] != 2'b00);
            default: err = 1'b1;
        endcase
        return err | ({1'b0, addr} >= ADDR_LIMIT);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << {lane[1], 1'b0};
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the right-aligned store data so every lane sees its own byte.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (size)
            2'b00:   return {24'd0, shifted[7:0]};
            2'b01:   return {16'd0, shifted[15:0]};
            2'b10:   return word;
            default: return 32'd0;
        endcase
    endfunction

    state_e         state_q,     state_d;
    logic [3:0]     cnt_q,       cnt_d;
    logic           lat_write_q, lat_write_d;
    logic [1:0]     lat_size_q,  lat_size_d;
    logic [31:0]    lat_addr_q,  lat_addr_d;
    logic [31:0]    lat_wdata_q, lat_wdata_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_error_q, rsp_error_d;
    logic [31:0]    rsp_rdata_q, rsp_rdata_d;

    logic [31:0]    mem_q [DEPTH_WORDS];

    logic           commit_s;
    logic           err_s;
    logic           mem_we_s;
    logic [AW-1:0]  word_idx_s;
    logic [31:0]    rd_word_s;
    logic [3:0]     mask_s;
    logic [31:0]    wrep_s;
    logic [31:0]    store_word_s;
    logic [31:0]    load_data_s;

    assign word_idx_s  = lat_addr_q[AW+1:2];
    assign rd_word_s   = mem_q[word_idx_s];
    assign err_s       = access_error(lat_size_q, lat_addr_q);
    assign mask_s      = lane_mask(lat_size_q, lat_addr_q[1:0]);
    assign wrep_s      = lane_data(lat_size_q, lat_wdata_q);
    assign load_data_s = load_extract(lat_size_q, lat_addr_q[1:0], rd_word_s);
    assign mem_we_s    = commit_s & lat_write_q & ~err_s;

    // Merge the store data into the current word, lane by lane.
    always_comb begin
        store_word_s = rd_word_s;
        for (int b = 0; b < 4; b++) begin
            if (mask_s[b]) begin
                store_word_s[8*b +: 8] = wrep_s[8*b +: 8];
            end else begin
                store_word_s[8*b +: 8] = rd_word_s[8*b +: 8];
            end
        end
    end

    // Next-state and registered-output logic of the request/wait/response FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_write_d = lat_write_q;
        lat_size_d  = lat_size_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        rsp_rdata_d = rsp_rdata_q;
        commit_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d     = WAIT;
                    cnt_d       = 4'(WAIT_CYCLES);
                    lat_write_d = bus.req_write;
                    lat_size_d  = bus.req_size;
                    lat_addr_d  = bus.req_addr;
                    lat_wdata_d = bus.req_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit_s    = 1'b1;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = err_s;
                    if (err_s || lat_write_q) begin
                        rsp_rdata_d = 32'd0;
                    end else begin
                        rsp_rdata_d = load_data_s;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = 4'd0;
                rsp_valid_d = 1'b0;
                rsp_error_d = 1'b0;
                rsp_rdata_d = 32'd0;
            end
        endcase
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lat_write_q <= 1'b0;
            lat_size_q  <= 2'b00;
            lat_addr_q  <= 32'd0;
            lat_wdata_q <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_write_q <= lat_write_d;
            lat_size_q  <= lat_size_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Storage array: written only at commit, contents survive reset.
    always_ff @(posedge clock) begin
        if (!reset && mem_we_s) begin
            mem_q[word_idx_s] <= store_word_s;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: a WAIT_CYCLES=2 instance driven from a vector table plus
// reset/hold sequences, and a WAIT_CYCLES=0 instance run back-to-back.
module tb_data_mem_responder;

    localparam int W2 = 2;

    logic clock;
    logic reset;
    logic busy2;
    logic busy0;
    int   checks;
    int   failures;
    int   resp_cnt0;

    data_mem_responder_if bus2();
    data_mem_responder_if bus0();

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2),
        .busy  (busy2)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0),
        .busy  (busy0)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          hold;
    } vec_t;

    vec_t vecs[20];
    vec_t b2b[6];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Ready and busy are never high together, and count responses of the zero-wait unit.
    always @(negedge clock) begin
        if (!reset) begin
            check("ready_vs_busy2", 32'(bus2.req_ready & busy2), 32'd0);
            check("ready_vs_busy0", 32'(bus0.req_ready & busy0), 32'd0);
            if (bus0.rsp_valid) resp_cnt0++;
        end
    end

    task automatic run_txn(input vec_t v, input string nm);
        int lat;
        @(negedge clock);
        bus2.req_valid = 1'b1;
        bus2.req_write = v.wr;
        bus2.req_size  = v.sz;
        bus2.req_addr  = v.addr;
        bus2.req_wdata = v.wd;
        check({nm, ".ready"}, 32'(bus2.req_ready), 32'd1);
        @(posedge clock); #1;
        bus2.req_valid = 1'b0;
        bus2.req_write = ~v.wr;
        bus2.req_size  = 2'b11;
        bus2.req_addr  = 32'hFFFF_FFFC;
        bus2.req_wdata = 32'h0BAD_0BAD;
        lat = 0;
        while (!bus2.rsp_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        check({nm, ".latency"}, 32'(lat), 32'(W2 + 1));
        check({nm, ".rdata"}, bus2.rsp_rdata, v.exp_rd);
        check({nm, ".error"}, 32'(bus2.rsp_error), 32'(v.exp_err));
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clock); #1;
            check({nm, ".hold_valid"}, 32'(bus2.rsp_valid), 32'd1);
            check({nm, ".hold_rdata"}, bus2.rsp_rdata, v.exp_rd);
            check({nm, ".hold_ready"}, 32'(bus2.req_ready), 32'd0);
        end
        bus2.rsp_ready = 1'b1;
        @(posedge clock); #1;
        bus2.rsp_ready = 1'b0;
        check({nm, ".done_valid"}, 32'(bus2.rsp_valid), 32'd0);
        check({nm, ".done_busy"}, 32'(busy2), 32'd0);
    endtask

    initial begin
        int n;
        vec_t v;
        checks    = 0;
        failures  = 0;
        resp_cnt0 = 0;

        vecs[0]  = '{1'b1, 2'b10, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0, 0};
        vecs[1]  = '{1'b0, 2'b10, 32'h10,  32'h00000000, 32'hDEADBEEF, 1'b0, 0};
        vecs[2]  = '{1'b1, 2'b00, 32'h11,  32'h000000AA, 32'h00000000, 1'b0, 0};
        vecs[3]  = '{1'b0, 2'b10, 32'h10,  32'h00000000, 32'hDEADAAEF, 1'b0, 5};
        vecs[4]  = '{1'b0, 2'b01, 32'h12,  32'h00000000, 32'h0000DEAD, 1'b0, 0};
        vecs[5]  = '{1'b0, 2'b00, 32'h11,  32'h00000000, 32'h000000AA, 1'b0, 0};
        vecs[6]  = '{1'b0, 2'b01, 32'h13,  32'h00000000, 32'h00000000, 1'b1, 0};
        vecs[7]  = '{1'b1, 2'b10, 32'h12,  32'h11111111, 32'h00000000, 1'b1, 0};
        vecs[8]  = '{1'b0, 2'b11, 32'h10,  32'h00000000, 32'h00000000, 1'b1, 0};
        vecs[9]  = '{1'b0, 2'b10, 32'h400, 32'h00000000, 32'h00000000, 1'b1, 0};
        vecs[10] = '{1'b0, 2'b10, 32'h10,  32'h00000000, 32'hDEADAAEF, 1'b0, 0};
        vecs[11] = '{1'b1, 2'b10, 32'h20,  32'hCAFEF00D, 32'h00000000, 1'b0, 0};
        vecs[12] = '{1'b1, 2'b01, 32'h22,  32'hFFFF1234, 32'h00000000, 1'b0, 0};
        vecs[13] = '{1'b0, 2'b10, 32'h20,  32'h00000000, 32'h1234F00D, 1'b0, 0};
        vecs[14] = '{1'b0, 2'b01, 32'h20,  32'h00000000, 32'h0000F00D, 1'b0, 0};
        vecs[15] = '{1'b0, 2'b00, 32'h23,  32'h00000000, 32'h00000012, 1'b0, 0};
        vecs[16] = '{1'b1, 2'b00, 32'h3FF, 32'hFFFFFF5A, 32'h00000000, 1'b0, 0};
        vecs[17] = '{1'b0, 2'b00, 32'h3FF, 32'h00000000, 32'h0000005A, 1'b0, 0};
        vecs[18] = '{1'b0, 2'b00, 32'h400, 32'h00000000, 32'h00000000, 1'b1, 0};
        vecs[19] = '{1'b0, 2'b01, 32'h10,  32'h00000000, 32'h0000AAEF, 1'b0, 0};

        b2b[0] = '{1'b1, 2'b10, 32'h0, 32'h11223344, 32'h00000000, 1'b0, 0};
        b2b[1] = '{1'b0, 2'b10, 32'h0, 32'h00000000, 32'h11223344, 1'b0, 0};
        b2b[2] = '{1'b1, 2'b10, 32'h4, 32'h55667788, 32'h00000000, 1'b0, 0};
        b2b[3] = '{1'b0, 2'b10, 32'h4, 32'h00000000, 32'h55667788, 1'b0, 0};
        b2b[4] = '{1'b1, 2'b00, 32'h1, 32'h00000077, 32'h00000000, 1'b0, 0};
        b2b[5] = '{1'b0, 2'b10, 32'h0, 32'h00000000, 32'h11227744, 1'b0, 0};

        // Reset with a pending request and response handshake: reset must win.
        reset          = 1'b1;
        bus2.req_valid = 1'b1;
        bus2.req_write = 1'b0;
        bus2.req_size  = 2'b10;
        bus2.req_addr  = 32'h10;
        bus2.req_wdata = 32'd0;
        bus2.rsp_ready = 1'b1;
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'b0;
        bus0.req_size  = 2'b10;
        bus0.req_addr  = 32'h0;
        bus0.req_wdata = 32'd0;
        bus0.rsp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst.busy", 32'(busy2), 32'd0);
        check("rst.rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        check("rst.rsp_error", 32'(bus2.rsp_error), 32'd0);
        check("rst.rsp_rdata", bus2.rsp_rdata, 32'd0);
        @(negedge clock);
        reset          = 1'b0;
        bus2.req_valid = 1'b0;
        bus2.rsp_ready = 1'b0;
        #1;
        check("rst.req_ready", 32'(bus2.req_ready), 32'd1);

        for (int i = 0; i < 20; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of the wait phase of a store aborts it.
        @(negedge clock);
        bus2.req_valid = 1'b1;
        bus2.req_write = 1'b1;
        bus2.req_size  = 2'b10;
        bus2.req_addr  = 32'h20;
        bus2.req_wdata = 32'h12345678;
        @(posedge clock); #1;
        bus2.req_valid = 1'b0;
        check("abort.busy_wait", 32'(busy2), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort.busy", 32'(busy2), 32'd0);
        check("abort.rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        v = '{1'b0, 2'b10, 32'h20, 32'h0, 32'h1234F00D, 1'b0, 0};
        run_txn(v, "abort.reload");

        // Reset while a response is pending discards it.
        @(negedge clock);
        bus2.req_valid = 1'b1;
        bus2.req_write = 1'b0;
        bus2.req_size  = 2'b10;
        bus2.req_addr  = 32'h10;
        @(posedge clock); #1;
        bus2.req_valid = 1'b0;
        n = 0;
        while (!bus2.rsp_valid && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        check("discard.pending", 32'(bus2.rsp_rdata), 32'hDEADAAEF);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("discard.rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        check("discard.rsp_rdata", bus2.rsp_rdata, 32'd0);
        check("discard.busy", 32'(busy2), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Zero-wait unit: request held valid, responses always accepted.
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            bus0.req_valid = 1'b1;
            bus0.req_write = b2b[k].wr;
            bus0.req_size  = b2b[k].sz;
            bus0.req_addr  = b2b[k].addr;
            bus0.req_wdata = b2b[k].wd;
            n = 0;
            while (!bus0.req_ready && n < 10) begin
                @(negedge clock);
                n++;
            end
            check($sformatf("b2b%0d.gap", k), 32'(n), (k == 0) ? 32'd0 : 32'd1);
            @(posedge clock); #1;
            check($sformatf("b2b%0d.busy", k), 32'(busy0), 32'd1);
            check($sformatf("b2b%0d.early", k), 32'(bus0.rsp_valid), 32'd0);
            @(posedge clock); #1;
            check($sformatf("b2b%0d.valid", k), 32'(bus0.rsp_valid), 32'd1);
            check($sformatf("b2b%0d.rdata", k), bus0.rsp_rdata, b2b[k].exp_rd);
            check($sformatf("b2b%0d.error", k), 32'(bus0.rsp_error), 32'(b2b[k].exp_err));
        end
        @(negedge clock);
        bus0.req_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("b2b.responses", 32'(resp_cnt0), 32'd6);
        check("b2b.idle", 32'(busy0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
